// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external combinational adder between NREQ requesters.
// Each accepted operation runs IDLE -> EXEC -> RESP; operands are registered so the
// shared adder only ever sees stable values owned by the current transaction.
module adder_share_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*W-1:0]       req_a,
   input  logic [NREQ*W-1:0]       req_b,
   output logic [W-1:0]            add_a,
   output logic [W-1:0]            add_b,
   input  logic [W:0]              add_sum,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [W:0]              rsp_sum,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic                    busy,
   output logic [15:0]             done_cnt
);

   localparam int unsigned IdW = $clog2(NREQ);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e         state_q;
   logic [IdW-1:0] rr_ptr_q;
   logic [W-1:0]   op_a_q;
   logic [W-1:0]   op_b_q;
   logic [W:0]     rsp_sum_q;
   logic [IdW-1:0] rsp_id_q;
   logic [15:0]    done_cnt_q;

   logic           grant_found;
   logic [IdW-1:0] grant_idx;
   logic [IdW-1:0] scan_idx;

   // Pick the first valid requester at or above rr_ptr, wrapping modulo NREQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_idx = IdW'((32'(rr_ptr_q) + k) % NREQ);
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Ready is combinational so a requester sees its grant in the accepting cycle.
   always_comb begin
      req_ready = '0;
      if (state_q == StIdle && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Control FSM with all transaction state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         rsp_sum_q  <= '0;
         rsp_id_q   <= '0;
         done_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_found) begin
                  op_a_q   <= req_a[int'(grant_idx)*W +: W];
                  op_b_q   <= req_b[int'(grant_idx)*W +: W];
                  rsp_id_q <= grant_idx;
                  // Priority only moves on an accept, never on idle cycles.
                  rr_ptr_q <= (grant_idx == IdW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                  state_q  <= StExec;
               end
            end
            StExec: begin
               // add_sum is opaque; carry-out travels in its MSB untouched.
               rsp_sum_q <= add_sum;
               state_q   <= StResp;
            end
            StResp: begin
               if (rsp_ready) begin
                  done_cnt_q <= done_cnt_q + 16'd1;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign add_a     = op_a_q;
   assign add_b     = op_b_q;
   assign rsp_valid = (state_q == StResp);
   assign busy      = (state_q != StIdle);
   assign rsp_sum   = rsp_sum_q;
   assign rsp_id    = rsp_id_q;
   assign done_cnt  = done_cnt_q;

endmodule
